// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encodings and sizing helpers for the SPI frame sequencer
//   ST_IDLE..ST_GAP : 3-bit FSM encodings
//   len_dec         : frame-length decode, 0 selects the maximum length
//   edge_w          : width of a counter holding 0..2*max_w
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_XFER = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    function automatic int len_dec(input int len, input int max_w);
        return (len == 0) ? max_w : len;
    endfunction

    function automatic int edge_w(input int max_w);
        return $clog2(2 * max_w + 1);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK half-period divider and edge generator
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_en          : run the divider (XFER); when low SCLK follows i_cpol
//   i_div         : D, half-period is D+1 clocks
//   i_cpol        : idle level of SCLK
//   o_tick        : an SCLK edge happens on this clock edge
//   o_is_leading  : the pending edge moves SCLK away from its idle level
//   o_sclk        : registered SPI clock
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_cpol,
    output logic             o_tick,
    output logic             o_is_leading,
    output logic             o_sclk
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    always_comb begin
        o_tick = i_en && (cnt_q == i_div);
        cnt_d  = (i_en && !o_tick) ? cnt_q + 1'b1 : '0;
        sclk_d = !i_en ? i_cpol : (o_tick ? !sclk_q : sclk_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign o_is_leading = (sclk_q == i_cpol);
    assign o_sclk       = sclk_q;

endmodule

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: SPI frame sequencer with SCLK generation, CS timing and inter-frame gap
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_en, i_tx_empty, i_rx_full : start qualification from controller and FIFOs
//   i_cont                    : keep CS low across back-to-back frames
//   i_cpol, i_cpha            : SPI mode
//   i_frame_len, i_clk_div    : L (0 = MAX_W) and D (half-period D+1)
//   i_cs_hold, i_gap          : H CS-low cycles after last edge, G min CS-high cycles
//   o_tx_rd, o_tx_load, o_frame_init : LOAD-cycle datapath strobes
//   o_shift_en, o_sample_en, o_frame_done : registered strobes aligned to SCLK edges
//   o_sclk, o_cs_n            : SPI pins
//   o_state, o_busy           : FSM state and non-idle flag
module spi_xfer_seq
    import spi_seq_pkg::*;
#(
    parameter int MAX_W = 32,
    parameter int DIV_W = 8,
    parameter int GAP_W = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_tx_empty,
    input  logic                       i_rx_full,
    input  logic                       i_cont,
    input  logic                       i_cpol,
    input  logic                       i_cpha,
    input  logic [$clog2(MAX_W+1)-1:0] i_frame_len,
    input  logic [DIV_W-1:0]           i_clk_div,
    input  logic [GAP_W-1:0]           i_cs_hold,
    input  logic [GAP_W-1:0]           i_gap,
    output logic                       o_tx_rd,
    output logic                       o_tx_load,
    output logic                       o_frame_init,
    output logic                       o_shift_en,
    output logic                       o_sample_en,
    output logic                       o_frame_done,
    output logic                       o_sclk,
    output logic                       o_cs_n,
    output logic [2:0]                 o_state,
    output logic                       o_busy
);

    localparam int LW = $clog2(MAX_W + 1);
    localparam int EW = edge_w(MAX_W);

    state_t           state_q, state_d;
    logic [LW-1:0]    len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic [GAP_W-1:0] cnt_q, cnt_d, gap_len;
    logic             cpha_q, cpha_d, cpol_q, cpol_d, cs_n_q, cs_n_d;
    logic             shift_q, shift_d, sample_q, sample_d, done_q, done_d;
    logic             tick, lead, last, reload;

    // Outside IDLE the generator holds SCLK at the level latched in IDLE.
    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (state_q == ST_XFER),
        .i_div        (div_q),
        .i_cpol       (state_q == ST_IDLE ? i_cpol : cpol_q),
        .o_tick       (tick),
        .o_is_leading (lead),
        .o_sclk       (o_sclk)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        div_d    = div_q;
        edge_d   = edge_q;
        cnt_d    = cnt_q;
        cpha_d   = cpha_q;
        cpol_d   = cpol_q;
        cs_n_d   = cs_n_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;
        gap_len  = (i_gap == '0) ? GAP_W'(1) : i_gap;
        last     = (edge_q == EW'(2 * len_q - 1));
        reload   = i_cont && !i_tx_empty && !i_rx_full;
        case (state_q)
            ST_IDLE: begin
                cpol_d = i_cpol;
                if (i_en && !i_tx_empty && !i_rx_full) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                len_d   = LW'(len_dec(int'(i_frame_len), MAX_W));
                div_d   = i_clk_div;
                cpha_d  = i_cpha;
                cs_n_d  = 1'b0;
                edge_d  = '0;
                state_d = ST_XFER;
            end
            ST_XFER: if (tick) begin
                edge_d   = edge_q + 1'b1;
                sample_d = cpha_q ? !lead : lead;
                // CPHA=1 drives bit 0 from LOAD, so the first leading edge does not shift.
                shift_d  = cpha_q ? (lead && edge_q >= EW'(2)) : (!lead && !last);
                done_d   = last;
                if (last) begin
                    state_d = reload ? ST_LOAD : (i_cs_hold != '0) ? ST_HOLD : ST_GAP;
                    cnt_d   = (i_cs_hold != '0) ? i_cs_hold : gap_len;
                    cs_n_d  = !reload && (i_cs_hold == '0);
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == GAP_W'(1)) begin
                    state_d = ST_GAP;
                    cnt_d   = gap_len;
                    cs_n_d  = 1'b1;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == GAP_W'(1)) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            div_q    <= '0;
            edge_q   <= '0;
            cnt_q    <= '0;
            cpha_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            cnt_q    <= cnt_d;
            cpha_q   <= cpha_d;
            cpol_q   <= cpol_d;
            cs_n_q   <= cs_n_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign o_tx_rd      = (state_q == ST_LOAD);
    assign o_tx_load    = (state_q == ST_LOAD);
    assign o_frame_init = (state_q == ST_LOAD);
    assign o_shift_en   = shift_q;
    assign o_sample_en  = sample_q;
    assign o_frame_done = done_q;
    assign o_cs_n       = cs_n_q;
    assign o_state      = state_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: scoreboard bench for the SPI frame sequencer
module tb_spi_xfer_seq;

    typedef struct packed {
        int samp;
        int shift;
        int xfer;
        int tog;
        int samp_hi;
        int shift_hi;
    } frame_t;

    logic       i_clk = 0, i_rst = 1, i_en = 0, i_tx_empty = 1, i_rx_full = 0;
    logic       i_cont = 0, i_cpol = 0, i_cpha = 0;
    logic [5:0] i_frame_len = 0;
    logic [7:0] i_clk_div = 0;
    logic [3:0] i_cs_hold = 0, i_gap = 0;
    logic       o_tx_rd, o_tx_load, o_frame_init, o_shift_en, o_sample_en, o_frame_done;
    logic       o_sclk, o_cs_n, o_busy;
    logic [2:0] o_state;

    int total = 0, bad = 0;
    frame_t exp_q[$], obs_q[$];
    int g_rd, g_cs_hi, g_mid, g_hold, g_gap, g_gap_cs, g_to;

    spi_xfer_seq #(.MAX_W(32), .DIV_W(8), .GAP_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_tx_empty(i_tx_empty),
        .i_rx_full(i_rx_full), .i_cont(i_cont), .i_cpol(i_cpol), .i_cpha(i_cpha),
        .i_frame_len(i_frame_len), .i_clk_div(i_clk_div), .i_cs_hold(i_cs_hold), .i_gap(i_gap),
        .o_tx_rd(o_tx_rd), .o_tx_load(o_tx_load), .o_frame_init(o_frame_init),
        .o_shift_en(o_shift_en), .o_sample_en(o_sample_en), .o_frame_done(o_frame_done),
        .o_sclk(o_sclk), .o_cs_n(o_cs_n), .o_state(o_state), .o_busy(o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    // Per-frame observation: strobes and SCLK activity between LOAD and frame_done.
    initial begin
        frame_t f;
        logic prev;
        f = '0;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) f = '0;
            else begin
                if (o_sample_en) begin f.samp++; if (o_sclk) f.samp_hi++; end
                if (o_shift_en) begin f.shift++; if (o_sclk) f.shift_hi++; end
                if (o_state == 3'd2) f.xfer++;
                if (o_sclk != prev) f.tog++;
                if (o_frame_done) obs_q.push_back(f);
                if (o_tx_rd) f = '0;
            end
            prev = o_sclk;
        end
    end

    function automatic frame_t model(input int l, input int d, input logic cpol, input logic cpha);
        frame_t e;
        e.samp     = l;
        e.shift    = l - 1;
        e.xfer     = 2 * l * (d + 1);
        e.tog      = 2 * l;
        e.samp_hi  = (cpol ^ cpha) ? 0 : l;
        e.shift_hi = (cpol ^ cpha) ? l - 1 : 0;
        return e;
    endfunction

    task automatic cfg(input int len, input int div, input logic cpol, input logic cpha,
                       input int hold, input int gap, input logic cont);
        i_frame_len = 6'(len);
        i_clk_div   = 8'(div);
        i_cpol      = cpol;
        i_cpha      = cpha;
        i_cs_hold   = 4'(hold);
        i_gap       = 4'(gap);
        i_cont      = cont;
    endtask

    // Feeds a TX FIFO of `words` entries until `frames` frames finished and the FSM is idle.
    task automatic run(input int words, input int frames, input int budget);
        int got = 0, left = words;
        g_rd = 0; g_cs_hi = 0; g_mid = 0; g_hold = 0; g_gap = 0; g_gap_cs = 0; g_to = 1;
        i_tx_empty = (left == 0);
        i_en = 1;
        for (int c = 0; c < budget && g_to != 0; c++) begin
            @(negedge i_clk);
            if (o_tx_rd) begin g_rd++; left--; end
            i_tx_empty = (left <= 0);
            if (o_frame_done) got++;
            if (o_cs_n && (o_state == 3'd2 || o_state == 3'd3 || (o_state == 3'd1 && g_rd > 1))) g_cs_hi++;
            if (got < frames && g_rd > 0 && (o_state == 3'd3 || o_state == 3'd4)) g_mid++;
            if (o_state == 3'd3) g_hold++;
            if (o_state == 3'd4) begin g_gap++; if (o_cs_n) g_gap_cs++; end
            if (got >= frames && o_state == 3'd0) g_to = 0;
        end
        i_en = 0;
        total++;
        if (g_to != 0) begin bad++; $display("FAIL run_timeout got=%0d frames=%0d", got, frames); end
    endtask

    task automatic test_reset();
        i_rst = 1;
        repeat (3) @(negedge i_clk);
        total++; if (o_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", o_state); end
        total++; if (o_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n got=%b exp=1", o_cs_n); end
        total++; if (o_sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", o_sclk); end
        total++;
        if ({o_tx_rd, o_shift_en, o_sample_en, o_frame_done, o_busy} !== 5'b0) begin
            bad++; $display("FAIL rst_strobes got=%b exp=00000", {o_tx_rd, o_shift_en, o_sample_en, o_frame_done, o_busy});
        end
        i_rst = 0;
        repeat (2) @(negedge i_clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_single();
        frame_t ob, ex;
        cfg(8, 1, 0, 0, 0, 2, 0);
        exp_q.push_back(model(8, 1, 0, 0));
        run(1, 1, 200);
        total++; if (g_rd !== 1) begin bad++; $display("FAIL single_tx_rd got=%0d exp=1", g_rd); end
        total++; if (g_hold !== 0) begin bad++; $display("FAIL single_hold got=%0d exp=0", g_hold); end
        total++; if (g_gap !== 2) begin bad++; $display("FAIL single_gap got=%0d exp=2", g_gap); end
        total++; if (g_gap_cs !== 2) begin bad++; $display("FAIL single_gap_cs got=%0d exp=2", g_gap_cs); end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL single_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL single_frame got=%p exp=%p", ob, ex); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_cpha1();
        frame_t ob, ex;
        cfg(4, 0, 1, 1, 2, 0, 0);
        repeat (2) @(negedge i_clk);
        total++; if (o_sclk !== 1'b1) begin bad++; $display("FAIL cpha1_idle_sclk got=%b exp=1", o_sclk); end
        exp_q.push_back(model(4, 0, 1, 1));
        run(1, 1, 100);
        total++; if (g_hold !== 2) begin bad++; $display("FAIL cpha1_hold got=%0d exp=2", g_hold); end
        total++; if (g_gap !== 1) begin bad++; $display("FAIL cpha1_gap got=%0d exp=1", g_gap); end
        total++; if (o_sclk !== 1'b1) begin bad++; $display("FAIL cpha1_end_sclk got=%b exp=1", o_sclk); end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL cpha1_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL cpha1_frame got=%p exp=%p", ob, ex); end end
        end
    endtask

    task automatic test_back_to_back();
        frame_t ob, ex;
        cfg(8, 0, 0, 0, 1, 1, 1);
        repeat (3) exp_q.push_back(model(8, 0, 0, 0));
        run(3, 3, 400);
        i_cont = 0;
        total++; if (g_rd !== 3) begin bad++; $display("FAIL b2b_tx_rd got=%0d exp=3", g_rd); end
        total++; if (g_cs_hi !== 0) begin bad++; $display("FAIL b2b_cs_high got=%0d exp=0", g_cs_hi); end
        total++; if (g_mid !== 0) begin bad++; $display("FAIL b2b_hold_gap got=%0d exp=0", g_mid); end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL b2b_frame got=%p exp=%p", ob, ex); end end
        end
    endtask

    task automatic test_rx_full_block();
        frame_t ob, ex;
        int left = 2, rd = 0, seen = 0, ok = 0;
        cfg(8, 0, 0, 0, 1, 1, 1);
        repeat (2) exp_q.push_back(model(8, 0, 0, 0));
        i_tx_empty = 0;
        i_en = 1;
        for (int c = 0; c < 20 && rd == 0; c++) begin
            @(negedge i_clk);
            if (o_tx_rd) begin rd++; left--; end
        end
        repeat (3) @(negedge i_clk);
        i_rx_full = 1;
        for (int c = 0; c < 40 && ok == 0; c++) begin
            @(negedge i_clk);
            if (o_tx_rd) rd++;
            if (o_state == 3'd3 || o_state == 3'd4) seen++;
            if (o_frame_done) ok = 1;
        end
        total++; if (ok != 1) begin bad++; $display("FAIL rxf_frame1_timeout got=%0d exp=1", ok); end
        repeat (30) begin
            @(negedge i_clk);
            if (o_tx_rd) rd++;
            if (o_state == 3'd3 || o_state == 3'd4) seen++;
        end
        total++; if (rd !== 1) begin bad++; $display("FAIL rxf_blocked_rd got=%0d exp=1", rd); end
        total++; if (seen !== 2) begin bad++; $display("FAIL rxf_hold_gap got=%0d exp=2", seen); end
        total++; if (o_state !== 3'd0 || o_cs_n !== 1'b1) begin bad++; $display("FAIL rxf_idle got=%0d/%b exp=0/1", o_state, o_cs_n); end
        i_rx_full = 0;
        ok = 0;
        for (int c = 0; c < 60 && ok == 0; c++) begin
            @(negedge i_clk);
            if (o_tx_rd) begin rd++; left--; end
            i_tx_empty = (left <= 0);
            if (o_frame_done) ok = 1;
        end
        i_en = 0;
        i_cont = 0;
        total++; if (ok != 1 || rd !== 2) begin bad++; $display("FAIL rxf_frame2 got=%0d/%0d exp=1/2", ok, rd); end
        for (int c = 0; c < 20 && o_state != 3'd0; c++) @(negedge i_clk);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rxf_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL rxf_frame got=%p exp=%p", ob, ex); end end
        end
    endtask

    task automatic test_len_bounds();
        frame_t ob, ex;
        cfg(0, 0, 0, 1, 0, 0, 0);
        exp_q.push_back(model(32, 0, 0, 1));
        run(1, 1, 300);
        cfg(1, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(model(1, 0, 0, 0));
        run(1, 1, 50);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL len_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL len_frame got=%p exp=%p", ob, ex); end end
        end
    endtask

    task automatic test_midframe();
        frame_t ob, ex;
        int ok = 0;
        cfg(4, 1, 0, 0, 0, 0, 0);
        exp_q.push_back(model(4, 1, 0, 0));
        i_tx_empty = 0;
        i_en = 1;
        for (int c = 0; c < 10 && !o_tx_rd; c++) @(negedge i_clk);
        i_tx_empty = 1;
        i_en = 0;
        @(negedge i_clk);
        cfg(2, 3, 1, 1, 0, 0, 0);
        for (int c = 0; c < 60 && ok == 0; c++) begin
            @(negedge i_clk);
            if (o_frame_done) ok = 1;
        end
        for (int c = 0; c < 20 && o_state != 3'd0; c++) @(negedge i_clk);
        total++; if (ok != 1 || o_state !== 3'd0) begin bad++; $display("FAIL mid_timeout got=%0d/%0d exp=1/0", ok, o_state); end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL mid_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL mid_frame got=%p exp=%p", ob, ex); end end
        end
    endtask

    task automatic test_reset_mid();
        frame_t ob, ex;
        int tog = 0;
        logic prev;
        cfg(8, 1, 0, 0, 0, 2, 0);
        repeat (2) @(negedge i_clk);
        prev = o_sclk;
        i_tx_empty = 0;
        i_en = 1;
        for (int c = 0; c < 100 && tog < 5; c++) begin
            @(negedge i_clk);
            if (o_sclk != prev && o_state == 3'd2) tog++;
            prev = o_sclk;
        end
        total++; if (tog != 5 || o_sclk !== 1'b1) begin bad++; $display("FAIL rmid_reach got=%0d/%b exp=5/1", tog, o_sclk); end
        i_rst = 1;
        i_en = 0;
        i_tx_empty = 1;
        @(negedge i_clk);
        total++; if (o_state !== 3'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", o_state); end
        total++; if (o_cs_n !== 1'b1 || o_sclk !== 1'b0) begin bad++; $display("FAIL rmid_pins got=%b/%b exp=1/0", o_cs_n, o_sclk); end
        total++; if (o_frame_done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", o_frame_done); end
        @(negedge i_clk);
        i_rst = 0;
        repeat (4) @(negedge i_clk);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        exp_q.push_back(model(8, 1, 0, 0));
        run(1, 1, 200);
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rmid_frame missing exp=%p", ex); end
            else begin ob = obs_q.pop_front(); if (ob !== ex) begin bad++; $display("FAIL rmid_frame got=%p exp=%p", ob, ex); end end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cpha1();
        test_back_to_back();
        test_rx_full_block();
        test_len_bounds();
        test_midframe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
